// File: rtl/timer_prog_arbiter_if.sv
// Requester bus and timer write port of the programmable-timer arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: req_valid is held by each requester until its req_ready pulse.
//
// master : requester side (drives requests, observes accepts and timer writes)
// slave  : arbiter side   (accepts requests, drives the timer write port)
interface timer_prog_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [2*NREQ-1:0]  req_ch;
  logic [2*NREQ-1:0]  req_mode;
  logic [32*NREQ-1:0] req_val;
  logic [NREQ-1:0]    req_ready;
  logic               counter_we;
  logic [1:0]         counter_ch;
  logic [31:0]        counter_val;

  modport master (
    output req_valid, req_ch, req_mode, req_val,
    input  req_ready, counter_we, counter_ch, counter_val
  );

  modport slave (
    input  req_valid, req_ch, req_mode, req_val,
    output req_ready, counter_we, counter_ch, counter_val
  );
endinterface

// File: rtl/timer_prog_arbiter.sv
// Round-robin arbiter sharing a 3-channel timer write port; syncs expiry bits into sticky irq flags.
// Latency: req_ready 1 cycle after grant, first timer write 1 cycle after req_ready; irq 1 cycle after sync.
// Backpressure: no grant while busy or while the previous accept/write is still on the bus.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        requester bus + timer write port (slave side)
//   cnt_out    counter outputs, asynchronous to clk
//   irq_clr    per-channel level clear for irq_pend
//   irq_pend   sticky expiry flags
//   busy       sequencer not idle
//   err        one-cycle pulse with the accept of an illegal request
module timer_prog_arbiter #(
  parameter int NREQ   = 2,
  parameter int SETTLE = 1024,
  parameter int SYNC   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  timer_prog_arbiter_if.slave  bus,
  input  logic [2:0]           cnt_out,
  input  logic [2:0]           irq_clr,
  output logic [2:0]           irq_pend,
  output logic                 busy,
  output logic                 err
);
  localparam int PW = $clog2(NREQ);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CTRL,
    ST_LOAD,
    ST_SETTLE
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [1:0]      shadow_mode;
  logic [1:0]      lat_ch;
  logic [1:0]      lat_mode;
  logic [31:0]     lat_val;
  logic [SW-1:0]   settle_cnt;

  logic [NREQ-1:0] ready_q;
  logic            we_q;
  logic [1:0]      ch_q;
  logic [31:0]     val_q;
  logic            busy_q;
  logic            err_q;

  // Round-robin pick starting at rr_ptr.
  logic            found;
  logic [PW-1:0]   gnt;
  logic [1:0]      g_ch;
  logic [1:0]      g_mode;
  logic [31:0]     g_val;
  logic            grant_ok;

  always_comb begin : arb_pick
    int j;
    found = 1'b0;
    gnt   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        gnt   = PW'(j);
      end
    end
  end

  assign g_ch   = bus.req_ch[2*gnt +: 2];
  assign g_mode = bus.req_mode[2*gnt +: 2];
  assign g_val  = bus.req_val[32*gnt +: 32];

  // The accepted requester still shows req_valid during its req_ready cycle,
  // so grants wait for that pulse to pass. Holding off while a write is on
  // the bus spaces back-to-back same-mode loads one write every 3 cycles.
  assign grant_ok = found && (ready_q == '0) && !we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      shadow_mode <= 2'b00;
      lat_ch      <= '0;
      lat_mode    <= '0;
      lat_val     <= '0;
      settle_cnt  <= '0;
      ready_q     <= '0;
      we_q        <= 1'b0;
      ch_q        <= '0;
      val_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ready_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_ok) begin
            rr_ptr   <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            lat_ch   <= g_ch;
            lat_mode <= g_mode;
            lat_val  <= g_val;
            ready_q  <= NREQ'(1) << gnt;
            if (g_ch == 2'd3 || g_mode == 2'b10) begin
              err_q <= 1'b1;
            end else if (g_mode != shadow_mode) begin
              state  <= ST_CTRL;
              busy_q <= 1'b1;
            end else begin
              state  <= ST_LOAD;
              busy_q <= 1'b1;
            end
          end
        end
        ST_CTRL: begin
          // The control word is shared by all channels; shadow tracks it.
          we_q        <= 1'b1;
          ch_q        <= 2'd3;
          val_q       <= {29'd0, lat_mode, 1'b0};
          shadow_mode <= lat_mode;
          state       <= ST_LOAD;
        end
        ST_LOAD: begin
          we_q  <= 1'b1;
          ch_q  <= lat_ch;
          val_q <= lat_val;
          if (SETTLE == 0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            settle_cnt <= SW'(SETTLE - 1);
            state      <= ST_SETTLE;
          end
        end
        default: begin
          // Give the slow divided counter clock time to latch the load.
          if (settle_cnt == '0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.counter_we  = we_q;
  assign bus.counter_ch  = ch_q;
  assign bus.counter_val = val_q;
  assign busy            = busy_q;
  assign err             = err_q;

  // Expiry synchroniser + rising-edge detector. Flops reset low, so a
  // counter output already high at reset release yields one edge.
  logic [SYNC-1:0][2:0] sync_q;
  logic [2:0]           prev_q;
  logic [2:0]           rise;
  logic [2:0]           pend_q;

  assign rise = sync_q[SYNC-1] & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      sync_q[0] <= cnt_out;
      for (int i = 1; i < SYNC; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC-1];
      // A new edge beats a simultaneous clear.
      pend_q <= rise | (pend_q & ~irq_clr);
    end
  end

  assign irq_pend = pend_q;
endmodule

// File: tb/tb_timer_prog_arbiter.sv
`timescale 1ns/1ps
module tb_timer_prog_arbiter;
  localparam int NREQ   = 2;
  localparam int SETTLE = 6;
  localparam int SYNC   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cnt_out, irq_clr, irq_pend;
  logic       busy, err;

  always #5 clk = ~clk;

  timer_prog_arbiter_if #(.NREQ(NREQ)) bus ();

  timer_prog_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnt_out(cnt_out), .irq_clr(irq_clr),
    .irq_pend(irq_pend), .busy(busy), .err(err)
  );

  typedef struct packed { logic [1:0] ch; logic [1:0] mode; logic [31:0] val; } req_t;
  typedef struct { int idx; logic err; int gap; } acc_t;
  typedef struct { logic [1:0] ch; logic [31:0] val; int off; } wr_t;

  acc_t acc_q[$];
  wr_t  wr_q[$];
  req_t rq[NREQ][$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;
  int cyc = 0, last_acc = 0, busy_run = 0, busy_last = 0;
  logic [1:0] m_shadow;
  int m_rr, m_next_gap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: one accept per request, optional control
  // write on a mode change, then the load; spacing to the next accept when
  // the other requests stay pending.
  task automatic model_accept(input int idx, input req_t r);
    acc_t a;
    wr_t  w;
    int   nw;
    a.idx = idx;
    a.gap = m_next_gap;
    a.err = (r.ch == 2'd3) || (r.mode == 2'b10);
    acc_q.push_back(a);
    if (a.err) begin
      m_next_gap = 2;
    end else begin
      nw = 0;
      if (r.mode != m_shadow) begin
        w.ch = 2'd3; w.val = {29'd0, r.mode, 1'b0}; w.off = 1;
        wr_q.push_back(w);
        m_shadow = r.mode;
        nw = 1;
      end
      w.ch = r.ch; w.val = r.val; w.off = nw + 1;
      wr_q.push_back(w);
      nw++;
      m_next_gap = nw + ((SETTLE > 0) ? SETTLE + 1 : 2);
    end
  endtask

  task automatic apply();
    req_t h;
    for (int r = 0; r < NREQ; r++) begin
      if (rq[r].size() > 0) begin
        h = rq[r][0];
        bus.req_valid[r]         = 1'b1;
        bus.req_ch[2*r +: 2]     = h.ch;
        bus.req_mode[2*r +: 2]   = h.mode;
        bus.req_val[32*r +: 32]  = h.val;
      end else begin
        bus.req_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic plan_and_run(input int budget);
    req_t cp[NREQ][$];
    int   g, c;
    bit   any;
    logic [NREQ-1:0] rdy;
    for (int r = 0; r < NREQ; r++) cp[r] = rq[r];
    m_next_gap = -1;
    forever begin
      any = 1'b0;
      g   = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!any && cp[(m_rr + k) % NREQ].size() > 0) begin
          any = 1'b1;
          g   = (m_rr + k) % NREQ;
        end
      end
      if (!any) break;
      model_accept(g, cp[g].pop_front());
      m_rr = (g + 1) % NREQ;
    end
    apply();
    c = 0;
    while ((rq[0].size() > 0 || rq[1].size() > 0) && c < budget) begin
      @(negedge clk); rdy = bus.req_ready;
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++)
        if (rdy[r] && rq[r].size() > 0) void'(rq[r].pop_front());
      apply();
      c++;
    end
    check("drive_done", (c < budget), 1);
    c = 0;
    while ((acc_q.size() > 0 || wr_q.size() > 0 || busy) && c < budget) begin
      @(negedge clk); c++;
    end
    repeat (2) @(negedge clk);
    check("drain_acc", acc_q.size(), 0);
    check("drain_wr", wr_q.size(), 0);
  endtask

  task automatic set_req(input int r, input logic [1:0] ch, input logic [1:0] mode, input logic [31:0] val);
    bus.req_valid[r]        = 1'b1;
    bus.req_ch[2*r +: 2]    = ch;
    bus.req_mode[2*r +: 2]  = mode;
    bus.req_val[32*r +: 32] = val;
  endtask

  task automatic wait_for(input int kind, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      @(negedge clk);
      case (kind)
        0:       hit = (bus.req_ready != '0);
        1:       hit = bus.counter_we;
        3:       hit = bus.counter_we && (bus.counter_ch == 2'd2);
        default: hit = !busy;
      endcase
    end
    check(name, hit, 1);
  endtask

  // Scoreboard monitor.
  acc_t ma;
  wr_t  mw;
  always @(negedge clk) begin
    cyc++;
    if (!rst && mon_en) begin
      if (bus.counter_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got ch=%0d val=%0h expected no write", bus.counter_ch, bus.counter_val);
        end else begin
          mw = wr_q.pop_front();
          check("wr_ch", bus.counter_ch, mw.ch);
          check("wr_val", bus.counter_val, mw.val);
          check("wr_offset", cyc - last_acc, mw.off);
        end
      end
      if (bus.req_ready != '0) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_accept: got ready=%0b expected none", bus.req_ready);
        end else begin
          ma = acc_q.pop_front();
          check("acc_onehot", $onehot(bus.req_ready), 1);
          check("acc_idx", bus.req_ready, 64'd1 << ma.idx);
          check("acc_err", err, ma.err);
          if (ma.gap >= 0) check("acc_gap", cyc - last_acc, ma.gap);
          last_acc = cyc;
        end
      end else if (err) begin
        checks++; errors++;
        $display("FAIL err_without_accept: got err=1 expected 0");
      end
    end
    if (busy) busy_run++;
    else if (busy_run != 0) begin busy_last = busy_run; busy_run = 0; end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int   n;
    req_t t;
    rst = 1'b1; cnt_out = '0; irq_clr = '0;
    bus.req_valid = '0; bus.req_ch = '0; bus.req_mode = '0; bus.req_val = '0;
    m_rr = 0; m_shadow = 2'b00;
    repeat (3) @(posedge clk); #1;
    check("rst_we", bus.counter_we, 0);
    check("rst_ch", bus.counter_ch, 0);
    check("rst_val", bus.counter_val, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_pend", irq_pend, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single load, matching mode: no control write.
    rq[0].push_back('{ch: 2'd1, mode: 2'b00, val: 32'd5});
    plan_and_run(200);
    check("busy_len_load", busy_last, SETTLE + 1);

    // Expiry on channel 1, then clear while the level stays high.
    @(posedge clk); #1; cnt_out[1] = 1'b1; n = 0;
    while (!irq_pend[1] && n < 20) begin @(posedge clk); #1; n++; end
    check("irq1_latency", n, SYNC + 1);
    irq_clr[1] = 1'b1; @(posedge clk); #1; irq_clr[1] = 1'b0;
    check("irq1_clear", irq_pend[1], 0);
    repeat (3) @(posedge clk); #1;
    check("irq1_level_no_reset", irq_pend[1], 0);
    cnt_out[1] = 1'b0;

    // Mode change: control word then load.
    rq[0].push_back('{ch: 2'd0, mode: 2'b11, val: 32'd100});
    plan_and_run(200);
    check("busy_len_ctrl", busy_last, SETTLE + 2);

    // Two requesters held together: round-robin alternation.
    rq[0].push_back('{ch: 2'd2, mode: 2'b11, val: 32'h11});
    rq[0].push_back('{ch: 2'd0, mode: 2'b01, val: 32'h22});
    rq[1].push_back('{ch: 2'd1, mode: 2'b11, val: 32'h33});
    rq[1].push_back('{ch: 2'd2, mode: 2'b01, val: 32'h44});
    plan_and_run(400);

    // Illegal channel and illegal mode.
    rq[1].push_back('{ch: 2'd3, mode: 2'b00, val: 32'hdead});
    rq[1].push_back('{ch: 2'd1, mode: 2'b10, val: 32'hbeef});
    plan_and_run(200);

    // Randomised mix.
    for (int i = 0; i < 40; i++) begin
      t.ch   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      n      = $urandom_range(0, 9);
      t.mode = (n == 0) ? 2'b10 : (n < 4) ? 2'b00 : (n < 7) ? 2'b01 : 2'b11;
      t.val  = $urandom;
      rq[$urandom_range(0, 1)].push_back(t);
    end
    plan_and_run(2000);

    // Set beats simultaneous clear.
    @(posedge clk); #1; cnt_out[2] = 1'b1;
    repeat (SYNC + 2) @(posedge clk); #1;
    check("irq2_set", irq_pend[2], 1);
    cnt_out[2] = 1'b0;
    repeat (4) @(posedge clk); #1;
    cnt_out[2] = 1'b1;
    repeat (SYNC) @(posedge clk); #1;
    irq_clr[2] = 1'b1;
    @(posedge clk); #1; irq_clr[2] = 1'b0;
    check("irq2_set_wins", irq_pend[2], 1);
    cnt_out[2] = 1'b0;

    // Reset during SETTLE with another request pending.
    mon_en = 1'b0;
    set_req(0, 2'd2, 2'b01, 32'h55);
    wait_for(0, "r5a_grant");
    check("r5a_grant_idx", bus.req_ready, 2'b01);
    @(posedge clk); #1; bus.req_valid[0] = 1'b0;
    set_req(1, 2'd1, 2'b01, 32'h77);
    wait_for(3, "r5a_load");
    repeat (2) @(negedge clk);
    check("r5a_busy_settle", busy, 1);
    #2; rst = 1'b1; #1;
    check("r5a_rst_we", bus.counter_we, 0);
    check("r5a_rst_ch", bus.counter_ch, 0);
    check("r5a_rst_val", bus.counter_val, 0);
    check("r5a_rst_busy", busy, 0);
    check("r5a_rst_pend", irq_pend, 0);
    repeat (2) @(posedge clk); #1; rst = 1'b0;
    wait_for(0, "r5a_regrant");
    check("r5a_regrant_idx", bus.req_ready, 2'b10);
    wait_for(1, "r5a_ctrl");
    check("r5a_ctrl_ch", bus.counter_ch, 3);
    check("r5a_ctrl_val", bus.counter_val, 32'h2);
    @(posedge clk); #1; bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check("r5a_load_we", bus.counter_we, 1);
    check("r5a_load_ch", bus.counter_ch, 1);
    check("r5a_load_val", bus.counter_val, 32'h77);
    wait_for(2, "r5a_idle");

    // Reset during CTRL; counter output high across reset release.
    set_req(0, 2'd1, 2'b11, 32'h1234);
    wait_for(0, "r5b_grant");
    #1; rst = 1'b1; cnt_out[0] = 1'b1; #1;
    check("r5b_rst_we", bus.counter_we, 0);
    check("r5b_rst_ready", bus.req_ready, 0);
    check("r5b_rst_busy", busy, 0);
    repeat (3) @(posedge clk); #1; rst = 1'b0;
    wait_for(0, "r5b_regrant");
    check("r5b_regrant_idx", bus.req_ready, 2'b01);
    @(posedge clk); #1; bus.req_valid[0] = 1'b0;
    wait_for(1, "r5b_ctrl");
    check("r5b_ctrl_ch", bus.counter_ch, 3);
    check("r5b_ctrl_val", bus.counter_val, 32'h6);
    @(negedge clk);
    check("r5b_load_ch", bus.counter_ch, 1);
    check("r5b_load_val", bus.counter_val, 32'h1234);
    wait_for(2, "r5b_idle");
    check("irq0_edge_after_reset", irq_pend[0], 1);
    @(posedge clk); #1; irq_clr[0] = 1'b1;
    @(posedge clk); #1; irq_clr[0] = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("irq0_single_edge", irq_pend[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
